// File: rtl/entrada_jogo_pkg.sv
// entrada_pkg: shared types and helpers for the Bulls and Cows input front end.
//   state_t    : debounce FSM states
//   NDIG       : digits per code
//   DIG_MAX    : largest legal BCD digit
//   code_valid : 1 when every digit <= DIG_MAX and all digits are pairwise distinct
package entrada_pkg;
   typedef enum logic [2:0] {IDLE, PRESS_CHK, PRESSED, HELD, RELEASE_CHK, WAIT_RELEASE} state_t;
   localparam int NDIG = 4;
   localparam logic [3:0] DIG_MAX = 4'd9;
   function automatic logic code_valid(input logic [15:0] c);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (c[4*i +: 4] > DIG_MAX) ok = 1'b0;
         for (int j = i + 1; j < NDIG; j++)
            if (c[4*i +: 4] == c[4*j +: 4]) ok = 1'b0;
      end
      return ok;
   endfunction
endpackage

// File: rtl/entrada_jogo_debounce_fsm.sv
// debounce_fsm: synchronises the raw button, debounces it and emits one event per press.
//   clock_i     : system clock
//   reset_i     : synchronous active-high reset
//   btn_i       : raw asynchronous button
//   press_evt_o : high for exactly one cycle per accepted press
//   btn_level_o : debounced button level
module debounce_fsm
   import entrada_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W = 20
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic btn_i,
   output logic press_evt_o,
   output logic btn_level_o
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   logic sync1_q, btn_s_q, level_q, level_d, done;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign done = cnt_q >= CNT_LAST;
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      case (state_q)
         IDLE:         if (btn_s_q) state_d = PRESS_CHK;
         PRESS_CHK:    if (!btn_s_q) state_d = IDLE; else if (done) state_d = PRESSED;
         PRESSED:      begin state_d = HELD; level_d = 1'b1; end
         HELD:         if (!btn_s_q) state_d = RELEASE_CHK;
         RELEASE_CHK:  if (btn_s_q) state_d = HELD; else if (done) begin state_d = IDLE; level_d = 1'b0; end
         WAIT_RELEASE: if (!btn_s_q && done) begin state_d = IDLE; level_d = 1'b0; end
         default:      state_d = WAIT_RELEASE;
      endcase
      // Cleared on every state change; WAIT_RELEASE also restarts while the button is still down.
      cnt_d = (state_d != state_q || (state_q == WAIT_RELEASE && btn_s_q)) ? '0 :
              (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
   end
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         sync1_q <= 1'b0;
         btn_s_q <= 1'b0;
         state_q <= WAIT_RELEASE;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         btn_s_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end
   assign press_evt_o = state_q == PRESSED;
   assign btn_level_o = level_q;
endmodule

// File: rtl/entrada_jogo.sv
// entrada_jogo: input front end producing a clean enter pulse and a validated code snapshot.
//   clock        : system clock
//   reset        : synchronous active-high reset
//   code         : raw switches, [15:12] is digit 1
//   enter_button : raw bouncing button
//   enter_pulse  : one-cycle strobe per accepted press
//   code_out     : code snapshot taken on enter_pulse
//   code_ok      : snapshot is 4 distinct BCD digits
//   code_err     : snapshot is invalid
//   btn_level    : debounced button level
module entrada_jogo
   import entrada_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] code,
   input  logic        enter_button,
   output logic        enter_pulse,
   output logic [15:0] code_out,
   output logic        code_ok,
   output logic        code_err,
   output logic        btn_level
);
   logic press_evt, ok_q, ok_d, err_q, err_d;
   logic [15:0] code_m_q, code_s_q, code_out_q, code_out_d;
   debounce_fsm #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb (
      .clock_i(clock),
      .reset_i(reset),
      .btn_i(enter_button),
      .press_evt_o(press_evt),
      .btn_level_o(btn_level)
   );
   always_comb begin
      code_out_d = press_evt ? code_s_q : code_out_q;
      ok_d       = press_evt ? code_valid(code_s_q) : ok_q;
      err_d      = press_evt ? !code_valid(code_s_q) : err_q;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         code_m_q   <= '0;
         code_s_q   <= '0;
         code_out_q <= '0;
         ok_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         code_m_q   <= code;
         code_s_q   <= code_m_q;
         code_out_q <= code_out_d;
         ok_q       <= ok_d;
         err_q      <= err_d;
      end
   end
   assign enter_pulse = press_evt;
   assign code_out    = code_out_q;
   assign code_ok     = ok_q;
   assign code_err    = err_q;
endmodule

// File: tb/tb_entrada_jogo.sv
// tb_entrada_jogo: directed self-checking bench for entrada_jogo with a short debounce window.
module tb_entrada_jogo;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] code = 16'h0000;
   logic        enter_button = 1'b0;
   logic        enter_pulse, code_ok, code_err, btn_level;
   logic [15:0] code_out;
   int passed = 0;
   int total = 0;
   int fails = 0;

   entrada_jogo #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clock(clock),
      .reset(reset),
      .code(code),
      .enter_button(enter_button),
      .enter_pulse(enter_pulse),
      .code_out(code_out),
      .code_ok(code_ok),
      .code_err(code_err),
      .btn_level(btn_level)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [15:0] c, input logic ok, input logic err, input logic lvl);
      chk({tag, ".code_out"}, 32'(code_out), 32'(c));
      chk({tag, ".code_ok"}, 32'(code_ok), 32'(ok));
      chk({tag, ".code_err"}, 32'(code_err), 32'(err));
      chk({tag, ".btn_level"}, 32'(btn_level), 32'(lvl));
   endtask

   // Steps n cycles with inputs unchanged; a pulse is expected only at cycle exp_k (0 = never).
   task automatic run(input string tag, input int n, input int exp_k);
      for (int k = 1; k <= n; k++) begin
         step();
         chk(tag, 32'(enter_pulse), 32'(k == exp_k));
      end
   endtask

   task automatic press(input string tag, input logic [15:0] c);
      code = c;
      enter_button = 1'b1;
      run(tag, 20, 7);
   endtask

   task automatic release_btn(input string tag);
      enter_button = 1'b0;
      run(tag, 12, 0);
   endtask

   initial begin
      logic [35:0] bounce;
      bounce = 36'hFFFFFFFDB;
      repeat (3) step();
      chk_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
      chk("reset.pulse", 32'(enter_pulse), 32'd0);
      reset = 1'b0;
      run("idle", 10, 0);
      chk_out("idle", 16'h0000, 1'b0, 1'b0, 1'b0);

      press("clean", 16'h1234);
      chk_out("clean", 16'h1234, 1'b1, 1'b0, 1'b1);
      release_btn("clean_rel");
      chk_out("clean_rel", 16'h1234, 1'b1, 1'b0, 1'b0);

      // Bit k-1 of bounce is the button level before edge k: high 2, low 1, high 2, low 1, then high.
      code = 16'h9870;
      for (int k = 1; k <= 36; k++) begin
         enter_button = bounce[k-1];
         step();
         chk("bounce", 32'(enter_pulse), 32'(k == 13));
      end
      chk_out("bounce", 16'h9870, 1'b1, 1'b0, 1'b1);
      release_btn("bounce_rel");

      press("dup", 16'h1123);
      chk_out("dup", 16'h1123, 1'b0, 1'b1, 1'b1);
      release_btn("dup_rel");
      press("range", 16'h12A4);
      chk_out("range", 16'h12A4, 1'b0, 1'b1, 1'b1);
      release_btn("range_rel");

      enter_button = 1'b1;
      reset = 1'b1;
      run("held_rst", 3, 0);
      chk_out("held_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      run("held", 50, 0);
      chk_out("held", 16'h0000, 1'b0, 1'b0, 1'b0);
      release_btn("held_rel");
      press("after_held", 16'h1234);
      chk_out("after_held", 16'h1234, 1'b1, 1'b0, 1'b1);
      release_btn("after_held_rel");

      code = 16'h5678;
      enter_button = 1'b1;
      run("snap", 10, 7);
      code = 16'h0000;
      run("snap_hold", 15, 0);
      chk_out("snap_hold", 16'h5678, 1'b1, 1'b0, 1'b1);
      release_btn("snap_rel");
      chk_out("snap_rel", 16'h5678, 1'b1, 1'b0, 1'b0);
      press("next", 16'h0123);
      chk_out("next", 16'h0123, 1'b1, 1'b0, 1'b1);
      release_btn("next_rel");

      // Five edges after the rise the counter sits at 2 in PRESS_CHK.
      code = 16'h4567;
      enter_button = 1'b1;
      run("mid", 5, 0);
      reset = 1'b1;
      step();
      chk("mid_rst.pulse", 32'(enter_pulse), 32'd0);
      chk_out("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      run("mid_hold", 20, 0);
      chk_out("mid_hold", 16'h0000, 1'b0, 1'b0, 1'b0);
      release_btn("mid_rel");
      press("final", 16'h9870);
      chk_out("final", 16'h9870, 1'b1, 1'b0, 1'b1);
      release_btn("final_rel");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
